// File: rtl/or1200_vlx_pkg.sv
// ---------------------------------------------------------------------------
// or1200_vlx_pkg
// Shared definitions for the variable-length-code (VLX) bitstream writer.
// Contents:
//   vlx_ctrl_state_t : controller state encoding
//   VLX_MARKER       : byte value that must be followed by a stuffed byte
//   VLX_STUFF        : byte value inserted after every marker byte
//   vlx_sat_inc16    : saturating 16-bit increment used by byte counters
// ---------------------------------------------------------------------------
package or1200_vlx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    STORE = 3'd2,
    STUFF = 3'd3,
    PAD   = 3'd4
  } vlx_ctrl_state_t;

  localparam logic [7:0] VLX_MARKER = 8'hFF;
  localparam logic [7:0] VLX_STUFF  = 8'h00;

  // Counter that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] vlx_sat_inc16(input logic [15:0] val);
    if (val == 16'hFFFF) begin
      return 16'hFFFF;
    end
    return val + 16'd1;
  endfunction

endpackage

// File: rtl/or1200_vlx_ctrl.sv
// ---------------------------------------------------------------------------
// or1200_vlx_ctrl
// Control FSM of the VLX bitstream writer. On each set-bit instruction it has
// the datapath merge the current code, then drains every complete byte the
// datapath holds to memory over the store bus, inserting a 0x00 after every
// 0xFF marker byte. A flush pads any pending bits with 1s and drains the
// resulting byte. The CPU pipeline is stalled while the controller is busy.
//
// Ports
//   clk_i, rst_i      : clock (rising edge) and asynchronous active-high reset
//   op_valid_i        : one-cycle set-bit instruction issue
//   flush_i           : one-cycle bitstream flush command
//   stall_o           : CPU pipeline stall, high whenever not IDLE
//   dp_set_bit_op_o   : datapath merges the current code (IDLE issue cycle)
//   dp_store_byte_i   : datapath holds a complete byte
//   dp_byte_i [7:0]   : that byte, MSB first
//   dp_partial_i      : datapath holds 1..7 pending bits
//   dp_ack_o          : datapath byte consumed, datapath shifts
//   dp_pad_o          : datapath pads pending bits with 1s to a byte boundary
//   st_req_o          : store request, address/data held until st_ack_i
//   st_adr_o [31:0]   : store address (write pointer)
//   st_dat_o [7:0]    : store data
//   st_ack_i          : store acknowledge
//   spr_we_i          : SPR write of the write pointer (honoured only in IDLE)
//   spr_dat_i [31:0]  : SPR write data
//   spr_dat_o [31:0]  : current write pointer
//   byte_cnt_o [15:0] : saturating count of stored bytes (incl. stuffed bytes)
// ---------------------------------------------------------------------------
module or1200_vlx_ctrl
  import or1200_vlx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        op_valid_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        dp_set_bit_op_o,
  input  logic        dp_store_byte_i,
  input  logic [7:0]  dp_byte_i,
  input  logic        dp_partial_i,
  output logic        dp_ack_o,
  output logic        dp_pad_o,
  output logic        st_req_o,
  output logic [31:0] st_adr_o,
  output logic [7:0]  st_dat_o,
  input  logic        st_ack_i,
  input  logic        spr_we_i,
  input  logic [31:0] spr_dat_i,
  output logic [31:0] spr_dat_o,
  output logic [15:0] byte_cnt_o
);

  vlx_ctrl_state_t state_q, state_d;
  logic [31:0]     ptr_q, ptr_d;
  logic [15:0]     byte_cnt_q, byte_cnt_d;
  logic [7:0]      byte_r_q, byte_r_d;
  logic            flush_pending_q, flush_pending_d;

  logic            set_bit_op;
  logic            dp_ack;
  logic            dp_pad;
  logic            st_req;
  logic [7:0]      st_dat;

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    byte_cnt_d      = byte_cnt_q;
    byte_r_d        = byte_r_q;
    flush_pending_d = flush_pending_q;
    set_bit_op      = 1'b0;
    dp_ack          = 1'b0;
    dp_pad          = 1'b0;
    st_req          = 1'b0;
    st_dat          = 8'h00;

    case (state_q)
      IDLE: begin
        if (spr_we_i) begin
          ptr_d      = spr_dat_i;
          byte_cnt_d = 16'h0000;
        end
        if (op_valid_i) begin
          // A flush arriving with the op is remembered and run once the
          // op's bytes have drained.
          set_bit_op      = 1'b1;
          flush_pending_d = flush_i;
          state_d         = CHECK;
        end else if (flush_i) begin
          state_d = PAD;
        end
      end

      CHECK: begin
        if (dp_store_byte_i) begin
          byte_r_d = dp_byte_i;
          state_d  = STORE;
        end else if (flush_pending_q) begin
          state_d = PAD;
        end else begin
          state_d = IDLE;
        end
      end

      STORE: begin
        st_req = 1'b1;
        st_dat = byte_r_q;
        if (st_ack_i) begin
          dp_ack     = 1'b1;
          ptr_d      = ptr_q + 32'd1;
          byte_cnt_d = vlx_sat_inc16(byte_cnt_q);
          state_d    = (byte_r_q == VLX_MARKER) ? STUFF : CHECK;
        end
      end

      STUFF: begin
        // The datapath already shifted on the marker's ack, so no dp_ack here.
        st_req = 1'b1;
        st_dat = VLX_STUFF;
        if (st_ack_i) begin
          ptr_d      = ptr_q + 32'd1;
          byte_cnt_d = vlx_sat_inc16(byte_cnt_q);
          state_d    = CHECK;
        end
      end

      PAD: begin
        flush_pending_d = 1'b0;
        if (dp_partial_i) begin
          dp_pad  = 1'b1;
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      ptr_q           <= 32'h0000_0000;
      byte_cnt_q      <= 16'h0000;
      byte_r_q        <= 8'h00;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      byte_cnt_q      <= byte_cnt_d;
      byte_r_q        <= byte_r_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Combinational outputs are gated by rst_i so that every output is zero for
  // the whole reset interval, including the cycle reset lands mid-transfer.
  assign stall_o         = (state_q != IDLE) & ~rst_i;
  assign dp_set_bit_op_o = set_bit_op & ~rst_i;
  assign dp_ack_o        = dp_ack & ~rst_i;
  assign dp_pad_o        = dp_pad & ~rst_i;
  assign st_req_o        = st_req & ~rst_i;
  // Address/data are forced to zero while no request is outstanding.
  assign st_adr_o        = st_req_o ? ptr_q  : 32'h0000_0000;
  assign st_dat_o        = st_req_o ? st_dat : 8'h00;
  assign spr_dat_o       = ptr_q;
  assign byte_cnt_o      = byte_cnt_q;

endmodule

// File: doc/or1200_vlx_ctrl.md
OR1200_VLX_CTRL -- requirements
Module: or1200_vlx_ctrl

Interface
REQ-001 The block SHALL have input clk_i (1 bit), the clock; all state is updated on its rising edge.
REQ-002 The block SHALL have input rst_i (1 bit), the reset; it is asynchronous and active-high.
REQ-003 The block SHALL have input op_valid_i (1 bit), a one-cycle set-bit instruction issue.
REQ-004 The block SHALL have input flush_i (1 bit), a one-cycle bitstream flush command.
REQ-005 The block SHALL have output stall_o (1 bit), the CPU pipeline stall.
REQ-006 The block SHALL have output dp_set_bit_op_o (1 bit), which tells the datapath to merge the current code.
REQ-007 The block SHALL have input dp_store_byte_i (1 bit); high means the datapath holds a complete byte.
REQ-008 The block SHALL have input dp_byte_i (8 bits), the next byte from the datapath, MSB first.
REQ-009 The block SHALL have input dp_partial_i (1 bit); high means the datapath holds 1 to 7 pending bits.
REQ-010 The block SHALL have output dp_ack_o (1 bit), which tells the datapath the byte is consumed and it shifts.
REQ-011 The block SHALL have output dp_pad_o (1 bit), which tells the datapath to pad pending bits with 1s to a byte boundary.
REQ-012 The block SHALL have the store bus signals st_req_o (out, 1), st_adr_o (out, 32), st_dat_o (out, 8) and st_ack_i (in, 1).
REQ-013 The block SHALL have the SPR signals spr_we_i (in, 1), spr_dat_i (in, 32) and spr_dat_o (out, 32) for the write pointer.
REQ-014 The block SHALL have output byte_cnt_o (16 bits), the count of stored bytes.

Function
REQ-015 States SHALL be IDLE, CHECK, STORE, STUFF and PAD.
REQ-016 stall_o SHALL be high whenever the state is not IDLE, and low in IDLE.
REQ-017 In IDLE with op_valid_i=1, dp_set_bit_op_o SHALL be high in that same cycle only (combinational), and the next state SHALL be CHECK.
REQ-018 In IDLE with op_valid_i=0 and flush_i=1, the next state SHALL be PAD.
REQ-019 If op_valid_i and flush_i are both high in IDLE, the op SHALL be accepted and a flush_pending flag set; the flush SHALL run before returning to IDLE.
REQ-020 In CHECK, transitions SHALL be:
- dp_store_byte_i=1: latch dp_byte_i into byte_r, go to STORE.
- else if flush_pending=1: go to PAD.
- else: go to IDLE.
REQ-021 In STORE:
- st_req_o=1, st_adr_o=ptr, st_dat_o=byte_r, all held stable until st_ack_i.
- On st_ack_i: dp_ack_o pulses one cycle, ptr increments, byte_cnt increments.
- Next state is STUFF if byte_r==8'hFF, else CHECK.
REQ-022 In STUFF:
- st_req_o=1, st_dat_o=8'h00, st_adr_o=ptr, held until st_ack_i.
- On st_ack_i: ptr and byte_cnt increment, next state CHECK.
- dp_ack_o stays low.
REQ-023 In PAD:
- Clear flush_pending.
- If dp_partial_i=1, pulse dp_pad_o one cycle and go to CHECK; else go to IDLE.
REQ-024 st_req_o SHALL be low in IDLE, CHECK and PAD; st_dat_o and st_adr_o are don't-care while st_req_o is low.
REQ-025 st_ack_i received while st_req_o=0 SHALL be ignored.
REQ-026 ptr SHALL be 32 bits, wrapping from 32'hFFFFFFFF to 0; spr_dat_o SHALL equal ptr at all times.
REQ-027 spr_we_i SHALL load ptr from spr_dat_i and clear byte_cnt only in IDLE; in any other state it SHALL be ignored.
REQ-028 byte_cnt SHALL saturate at 16'hFFFF; stuffed 0x00 bytes SHALL be counted.
REQ-029 op_valid_i and flush_i received outside IDLE SHALL be ignored, since the CPU is stalled.

Reset
REQ-030 While rst_i is high, the block SHALL hold:
- state IDLE, ptr 0, byte_cnt 0, byte_r 0, flush_pending 0.
- All outputs 0.
REQ-031 Reset asserted mid-transfer SHALL drop st_req_o immediately (asynchronously) without waiting for st_ack_i.

Structure
REQ-032 The state enum vlx_ctrl_state_t and the constants VLX_MARKER=8'hFF and VLX_STUFF=8'h00 SHALL reside in package or1200_vlx_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the parent instantiates it alongside the bit-packing datapath.

Verification
REQ-034 The bench SHALL cover a single byte with 1-cycle ack: ptr=0x1000, op_valid_i, dp_store_byte_i=1 with byte 0x3C, then 0 -> one store of 0x3C at 0x1000, ptr=0x1001, byte_cnt=1, stall_o high for exactly 3 cycles.
REQ-035 The bench SHALL cover marker stuffing: byte 0xFF -> stores 0xFF@ptr then 0x00@ptr+1, a single dp_ack_o pulse, byte_cnt +2.
REQ-036 The bench SHALL cover back-to-back bytes with 3-cycle ack latency: bytes 0x12 then 0x34 -> two stores, each with st_adr_o/st_dat_o stable for the full request, and ptr +2.
REQ-037 The bench SHALL cover simultaneous op and flush: op_valid_i=flush_i=1, no complete byte, dp_partial_i=1 -> dp_pad_o pulse; the padded byte 0xBF is stored, then IDLE.
REQ-038 The bench SHALL cover wrap-around: ptr=0xFFFFFFFF, one byte -> ptr=0x00000000.
REQ-039 The bench SHALL cover reset mid-transfer: rst_i asserted while STORE waits for ack -> st_req_o falls immediately, and all outputs are 0 after release.
REQ-040 The bench SHALL cover an SPR write while busy: spr_we_i with 0x2000 during STORE -> ptr is unchanged.
